// File: rtl/uart_block_tx.sv
// uart_block_tx: sends a latched BLOCK_BYTES-wide block as back-to-back UART frames, most significant byte first.
// Defining UART_BLOCK_TX_PARITY_EN inserts an even-parity bit before each stop bit.
module uart_block_tx #(
   parameter int CLK_HZ      = 100000000,
   parameter int BAUD        = 9600,
   parameter int BLOCK_BYTES = 16
) (
   input  logic                               clk_100MHz,
   input  logic                               reset,
   input  logic                               start,
   input  logic [8*BLOCK_BYTES-1:0]           block_in,
   output logic                               ready,
   output logic                               busy,
   output logic                               done,
   output logic [$clog2(BLOCK_BYTES+1)-1:0]   byte_idx,
   output logic                               tx
);
   localparam int CPB = CLK_HZ / BAUD;
   localparam int CW  = $clog2(CPB);
   localparam int IW  = $clog2(BLOCK_BYTES + 1);
   localparam int BW  = 8 * BLOCK_BYTES;
   localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(BLOCK_BYTES - 1);

`ifdef UART_BLOCK_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
`endif

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [BW-1:0]   block_q, block_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            tx_q, tx_d;
`ifdef UART_BLOCK_TX_PARITY_EN
   logic            par_q, par_d;
`endif
   logic            bit_end, last_byte, accept, next_byte, load;
   logic [BW-1:0]   src;

   assign bit_end   = cnt_q == CNT_LAST;
   assign last_byte = idx_q >= IDX_LAST;

   always_ff @(posedge clk_100MHz or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         block_q <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
`ifdef UART_BLOCK_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         block_q <= block_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
`ifdef UART_BLOCK_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start ? START : IDLE;
         START:   state_d = bit_end ? DATA : START;
`ifdef UART_BLOCK_TX_PARITY_EN
         DATA:    state_d = (bit_end && bit_q == 3'd7) ? PARITY : DATA;
         PARITY:  state_d = bit_end ? STOP : PARITY;
`else
         DATA:    state_d = (bit_end && bit_q == 3'd7) ? STOP : DATA;
`endif
         STOP:    state_d = bit_end ? (last_byte ? DONE : START) : STOP;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The block register shifts left a byte per load so the next byte is always on top.
   always_comb begin
      ready     = state_q == IDLE;
      busy      = ~ready;
      done      = state_q == DONE;
      byte_idx  = idx_q;
      tx        = tx_q;
      accept    = ready && start;
      next_byte = state_q == STOP && bit_end && !last_byte;
      load      = accept || next_byte;
      src       = accept ? block_in : block_q;
      cnt_d     = (ready || done || bit_end) ? '0 : cnt_q + 1'b1;
      bit_d     = state_q == START ? 3'd0 : (state_q == DATA && bit_end) ? bit_q + 3'd1 : bit_q;
      shift_d   = load ? src[BW-1 -: 8] : (state_q == DATA && bit_end) ? shift_q >> 1 : shift_q;
      block_d   = load ? src << 8 : block_q;
      idx_d     = next_byte ? idx_q + 1'b1 : done ? '0 : idx_q;
`ifdef UART_BLOCK_TX_PARITY_EN
      par_d     = load ? ^src[BW-1 -: 8] : par_q;
      tx_d      = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_q : 1'b1;
`else
      tx_d      = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
`endif
   end
endmodule
